keypad_scanner: RTL and testbench
=================================

Name: keypad_scanner

Overview:
- Scans the 4x4 hex keypad matrix and debounces every key.
- Produces the 16-bit key_state vector, bit k = CHIP-8 hex key k held.
- Feeds the configuration-menu state block and the chip8 core, which both edge-detect on key_state themselves.
- Sits between the keypad PMOD pins and all key consumers.

Parameters:
- COL_CYCLES, 1000, clk cycles each column is driven before its rows are sampled; must be >= 4.
- DEBOUNCE_COUNT, 4, consecutive disagreeing samples of a key required to flip its state; must be >= 1.

Ports:
- clk_in  input  1  system clock
- rst_n_in  input  1  asynchronous active-low reset
- row_in  input  4  matrix rows from the pins, active-low, pulled up externally
- col_out  output  4  matrix column drive, active-low one-hot (exactly one bit 0)
- key_state_out  output  16  debounced key state, bit k = hex key k pressed
- frame_out  output  1  one-cycle pulse after the column-3 sample is processed

Behaviour:
- Reset (async assert, sync deassert by the system reset tree):
  - col_idx=0, dwell=0, col_out=4'b1110, key_state_out=0, all debounce counters 0, frame_out=0.
  - Row synchronizer flops reset to 4'b1111.
- Row synchronizer: 2-flop on row_in; row_sync lags the pins by 2 cycles.
- Column sequencer:
  - dwell counts 0..COL_CYCLES-1 while col_out = ~(1<<col_idx).
  - Sample point is dwell==COL_CYCLES-1; row_sync is used that cycle.
  - Next cycle: dwell=0, col_idx=(col_idx+1) mod 4 (3 wraps to 0), col_out updates.
  - Frame period = 4*COL_CYCLES cycles.
- Key mapping:
  - Physical (row r, column c) maps to hex key KEY_MAP[r][c].
  - KEY_MAP rows, c=0..3: {1,2,3,C}, {4,5,6,D}, {7,8,9,E}, {A,0,B,F}.
- Debounce at each sample point, for the 4 keys of the current column only:
  - raw = ~row_sync[r]; k = KEY_MAP[r][col_idx].
  - If raw == key_state[k]: cnt[k] <= 0.
  - Else if cnt[k] == DEBOUNCE_COUNT-1: key_state[k] <= raw, cnt[k] <= 0.
  - Else: cnt[k] <= cnt[k]+1.
  - Keys of other columns hold state and counter.
- Latency:
  - A clean press is seen at the next sample of its column.
  - key_state_out changes on the cycle after the DEBOUNCE_COUNT-th consecutive pressed sample.
  - Worst case (DEBOUNCE_COUNT*4+1)*COL_CYCLES+3 cycles. Release is symmetric.
- Glitch rejection: any agreeing sample clears the counter. A bounce shorter than DEBOUNCE_COUNT frames never reaches the output.
- key_state_out, frame_out: registered, no combinational path from row_in.
- frame_out: high exactly the cycle after the column-3 sample, together with any key_state update from that sample.
- Multiple simultaneous keys: each key is independent. Ghosting from 3-key rectangles is not corrected and is reported as sampled.
- Reset mid-scan: everything returns to reset values immediately; held keys re-debounce from zero after release.
- Counter width: $clog2(DEBOUNCE_COUNT+1); 16 counters total.

Decomposition:
- keypad_pkg holds: KEY_MAP (4x4 array of 4-bit hex codes), NUM_ROWS=4, NUM_COLS=4, NUM_KEYS=16.
- Sub-module key_debounce, instantiated 16 times. Inputs: clk_in, rst_n_in, sample_en (sample point AND column match), raw. Output: state.
- The sequencer and synchronizer stay in the top.

Test Plan (bench uses COL_CYCLES=8, DEBOUNCE_COUNT=3, frame = 32 cycles):
- Reset then idle (rows all 1) for 10 frames -> col_out cycles 1110, 1101, 1011, 0111 every 8 cycles; key_state_out stays 0; frame_out pulses every 32 cycles.
- Model holds row 1 low whenever column 1 is driven (key 5) -> bit 5 rises on the cycle after the 3rd column-1 sample. It stays 1 while held and falls 3 frames after release.
- Key 5 bounces: pressed for 2 frames, released for 1, then pressed steadily -> no output during the bounce; bit 5 asserts only after 3 consecutive pressed frames.
- Keys 0 (row 3, col 1) and F (row 3, col 3) held together -> key_state_out = 16'h8001 after debounce; releasing only F -> 16'h0001.
- Assert rst_n_in low mid-dwell with key 8 debounced high -> key_state_out=0, col_out=1110 in the same cycle, without a clock edge. After release with key 8 still held -> bit 8 reasserts after 3 column-1 samples.
- Key pressed only during non-sampled dwell cycles (pulse shorter than COL_CYCLES-3, away from the sample point) -> key_state_out unchanged.

Source files
------------

// File: rtl/keypad_pkg.sv
// Shared constants for the 4x4 hex keypad scanner: matrix geometry and the
// physical (row, column) to hex-key mapping.
package keypad_pkg;

    localparam int NUM_ROWS = 4;
    localparam int NUM_COLS = 4;
    localparam int NUM_KEYS = 16;

    typedef logic [3:0] key_code_t;

    // KEY_MAP[row][col] is the hex legend printed on that button.
    localparam key_code_t KEY_MAP [NUM_ROWS][NUM_COLS] = '{
        '{4'h1, 4'h2, 4'h3, 4'hC},
        '{4'h4, 4'h5, 4'h6, 4'hD},
        '{4'h7, 4'h8, 4'h9, 4'hE},
        '{4'hA, 4'h0, 4'hB, 4'hF}
    };

endpackage

// File: rtl/key_debounce.sv
// Per-key debouncer: the held state flips only after DEBOUNCE_COUNT
// consecutive disagreeing samples; any agreeing sample clears the count.
module key_debounce #(
    parameter int DEBOUNCE_COUNT = 4
) (
    input  logic clk_in,
    input  logic rst_n_in,
    input  logic sample_en,
    input  logic raw,
    output logic state
);

    localparam int CNT_W = $clog2(DEBOUNCE_COUNT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_COUNT - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             state_q, state_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (sample_en) begin
            if (raw == state_q) begin
                cnt_d = '0;
            end else if (cnt_q == CNT_LAST) begin
                state_d = raw;
                cnt_d   = '0;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign state = state_q;

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 hex keypad scanner: drives one active-low column at a time, samples the
// synchronized rows at the end of each column dwell and debounces all 16 keys.
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int COL_CYCLES     = 1000,
    parameter int DEBOUNCE_COUNT = 4
) (
    input  logic                clk_in,
    input  logic                rst_n_in,
    input  logic [NUM_ROWS-1:0] row_in,
    output logic [NUM_COLS-1:0] col_out,
    output logic [NUM_KEYS-1:0] key_state_out,
    output logic                frame_out
);

    localparam int DW_W = $clog2(COL_CYCLES);
    localparam logic [DW_W-1:0] DWELL_LAST = DW_W'(COL_CYCLES - 1);

    logic [DW_W-1:0]     dwell_q, dwell_d;
    logic [1:0]          col_idx_q, col_idx_d;
    logic [NUM_COLS-1:0] col_q, col_d;
    logic                frame_q, frame_d;
    logic [NUM_ROWS-1:0] sync1_q, sync2_q;
    logic                sample;

    logic [NUM_ROWS-1:0][NUM_COLS-1:0] key_hit;

    assign sample = (dwell_q == DWELL_LAST);

    // The column drive advances on the cycle after the sample point.
    always_comb begin
        dwell_d   = dwell_q + 1'b1;
        col_idx_d = col_idx_q;
        col_d     = col_q;
        frame_d   = 1'b0;
        if (sample) begin
            dwell_d   = '0;
            col_idx_d = col_idx_q + 2'd1;
            col_d     = ~(4'b0001 << col_idx_d);
            frame_d   = (col_idx_q == 2'd3);
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            dwell_q   <= '0;
            col_idx_q <= 2'd0;
            col_q     <= 4'b1110;
            frame_q   <= 1'b0;
            sync1_q   <= 4'b1111;
            sync2_q   <= 4'b1111;
        end else begin
            dwell_q   <= dwell_d;
            col_idx_q <= col_idx_d;
            col_q     <= col_d;
            frame_q   <= frame_d;
            sync1_q   <= row_in;
            sync2_q   <= sync1_q;
        end
    end

    for (genvar r = 0; r < NUM_ROWS; r++) begin : g_row
        for (genvar c = 0; c < NUM_COLS; c++) begin : g_col
            key_debounce #(
                .DEBOUNCE_COUNT(DEBOUNCE_COUNT)
            ) u_debounce (
                .clk_in   (clk_in),
                .rst_n_in (rst_n_in),
                .sample_en(sample && (col_idx_q == 2'(c))),
                .raw      (~sync2_q[r]),
                .state    (key_hit[r][c])
            );
        end
    end

    // Each debouncer state is a flop, so the remap keeps the output registered.
    always_comb begin
        key_state_out = '0;
        for (int r = 0; r < NUM_ROWS; r++) begin
            for (int c = 0; c < NUM_COLS; c++) begin
                key_state_out[KEY_MAP[r][c]] = key_hit[r][c];
            end
        end
    end

    assign col_out   = col_q;
    assign frame_out = frame_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: a physical keypad model drives the rows, and a
// sample-level reference model predicts column drive, key state and frame pulse.
module tb_keypad_scanner;

  localparam int COL_CYCLES     = 8;
  localparam int DEBOUNCE_COUNT = 3;
  localparam int FRAME          = 4 * COL_CYCLES;
  localparam int WORST_LAT      = (DEBOUNCE_COUNT * 4 + 1) * COL_CYCLES + 3;

  logic        clk_in   = 1'b0;
  logic        rst_n_in = 1'b1;
  logic [3:0]  row_in;
  logic [3:0]  col_out;
  logic [15:0] key_state_out;
  logic        frame_out;

  logic [15:0] pressed  = '0;
  logic [3:0]  glitch_n = 4'hF;
  int checks = 0;
  int passes = 0;

  int kmap [4][4] = '{'{1, 2, 3, 12}, '{4, 5, 6, 13}, '{7, 8, 9, 14}, '{10, 0, 11, 15}};

  // ---------------- clock / reset ----------------
  always #5 clk_in = ~clk_in;

  keypad_scanner #(
    .COL_CYCLES    (COL_CYCLES),
    .DEBOUNCE_COUNT(DEBOUNCE_COUNT)
  ) dut (
    .clk_in       (clk_in),
    .rst_n_in     (rst_n_in),
    .row_in       (row_in),
    .col_out      (col_out),
    .key_state_out(key_state_out),
    .frame_out    (frame_out)
  );

  // Physical keypad: a held key pulls its row low while its column is driven.
  always_comb begin
    row_in = glitch_n;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (!col_out[c] && pressed[kmap[r][c]]) row_in[r] = 1'b0;
  end

  // ---------------- reference model ----------------
  int          cyc = 0;
  logic [3:0]  h1 = 4'hF, h2 = 4'hF;
  logic [15:0] m_key = '0;
  logic        m_frame = 1'b0;
  int          m_cnt [16];
  int          m_col, m_k;
  logic        m_raw;

  always @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      cyc = 0; h1 = 4'hF; h2 = 4'hF; m_key = '0; m_frame = 1'b0;
      foreach (m_cnt[i]) m_cnt[i] = 0;
    end else begin
      m_frame = 1'b0;
      if (cyc % COL_CYCLES == COL_CYCLES - 1) begin
        m_col = (cyc / COL_CYCLES) % 4;
        for (int r = 0; r < 4; r++) begin
          m_k   = kmap[r][m_col];
          m_raw = ~h2[r];
          if (m_raw == m_key[m_k]) m_cnt[m_k] = 0;
          else begin
            m_cnt[m_k] = m_cnt[m_k] + 1;
            if (m_cnt[m_k] == DEBOUNCE_COUNT) begin
              m_key[m_k] = m_raw;
              m_cnt[m_k] = 0;
            end
          end
        end
        if (m_col == 3) m_frame = 1'b1;
      end
      h2 = h1; h1 = row_in; cyc++;
    end
  end

  function automatic logic [3:0] exp_col(input int c);
    logic [3:0] one_hot;
    one_hot = 4'b0001 << ((c / COL_CYCLES) % 4);
    return ~one_hot;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: bench did not complete, checks=%0d", checks);
    $fatal(1, "timeout");
  end

  // ---------------- tests ----------------
  task automatic test_reset();
    #2 rst_n_in = 1'b0;
    repeat (2) @(negedge clk_in);
    checks++;
    if ({col_out, key_state_out, frame_out} !== {4'b1110, 16'h0000, 1'b0})
      $display("FAIL reset_hold got col=%b key=%h frame=%b want col=1110 key=0000 frame=0",
               col_out, key_state_out, frame_out);
    else passes++;
    rst_n_in = 1'b1;
    #1;
    checks++;
    if ({col_out, key_state_out, frame_out} !== {4'b1110, 16'h0000, 1'b0})
      $display("FAIL reset_release got col=%b key=%h frame=%b want col=1110 key=0000 frame=0",
               col_out, key_state_out, frame_out);
    else passes++;
  endtask

  task automatic test_idle();
    int frames = 0;
    repeat (10 * FRAME) begin
      @(negedge clk_in);
      if (frame_out) frames++;
      checks++;
      if ({col_out, key_state_out, frame_out} !== {exp_col(cyc), m_key, m_frame})
        $display("FAIL idle cyc=%0d got col=%b key=%h frame=%b want col=%b key=%h frame=%b",
                 cyc, col_out, key_state_out, frame_out, exp_col(cyc), m_key, m_frame);
      else passes++;
    end
    checks++;
    if (frames !== 10) $display("FAIL idle_frames got %0d want 10", frames);
    else passes++;
  endtask

  task automatic test_single_key();
    int rise = -1;
    pressed[5] = 1'b1;
    for (int t = 1; t <= 6 * FRAME; t++) begin
      @(negedge clk_in);
      if (key_state_out[5] && rise < 0) rise = t;
      checks++;
      if ({col_out, key_state_out, frame_out} !== {exp_col(cyc), m_key, m_frame})
        $display("FAIL key5_press cyc=%0d got key=%h frame=%b want key=%h frame=%b",
                 cyc, key_state_out, frame_out, m_key, m_frame);
      else passes++;
    end
    checks++;
    if (rise < 0 || rise > WORST_LAT)
      $display("FAIL key5_latency got %0d cycles want 1..%0d", rise, WORST_LAT);
    else passes++;
    pressed[5] = 1'b0;
    repeat (5 * FRAME) begin
      @(negedge clk_in);
      checks++;
      if ({col_out, key_state_out, frame_out} !== {exp_col(cyc), m_key, m_frame})
        $display("FAIL key5_release cyc=%0d got key=%h frame=%b want key=%h frame=%b",
                 cyc, key_state_out, frame_out, m_key, m_frame);
      else passes++;
    end
    checks++;
    if (key_state_out !== 16'h0000) $display("FAIL key5_released got %h want 0000", key_state_out);
    else passes++;
  endtask

  task automatic test_bounce();
    int leak = 0;
    for (int phase = 0; phase < 3; phase++) begin
      pressed[5] = (phase != 1);
      repeat ((phase == 1) ? FRAME : (phase == 0 ? 2 * FRAME : 4 * FRAME)) begin
        @(negedge clk_in);
        if (phase < 2 && key_state_out[5]) leak++;
        checks++;
        if ({col_out, key_state_out, frame_out} !== {exp_col(cyc), m_key, m_frame})
          $display("FAIL bounce cyc=%0d phase=%0d got key=%h want key=%h",
                   cyc, phase, key_state_out, m_key);
        else passes++;
      end
    end
    checks++;
    if (leak !== 0) $display("FAIL bounce_leak got %0d high cycles want 0", leak);
    else passes++;
    checks++;
    if (key_state_out !== 16'h0020) $display("FAIL bounce_settled got %h want 0020", key_state_out);
    else passes++;
  endtask

  task automatic test_multi_key();
    logic [15:0] want [3] = '{16'h8001, 16'h0001, 16'h0000};
    logic [15:0] held [3] = '{16'h8001, 16'h0001, 16'h0000};
    pressed = '0;
    repeat (4 * FRAME) @(negedge clk_in);
    for (int s = 0; s < 3; s++) begin
      pressed = held[s];
      repeat (5 * FRAME) begin
        @(negedge clk_in);
        checks++;
        if ({col_out, key_state_out, frame_out} !== {exp_col(cyc), m_key, m_frame})
          $display("FAIL multi cyc=%0d step=%0d got key=%h want key=%h", cyc, s, key_state_out, m_key);
        else passes++;
      end
      checks++;
      if (key_state_out !== want[s]) $display("FAIL multi_step%0d got %h want %h", s, key_state_out, want[s]);
      else passes++;
    end
  endtask

  task automatic test_reset_mid();
    pressed = 16'h0100;
    repeat (5 * FRAME) @(negedge clk_in);
    checks++;
    if (key_state_out !== 16'h0100) $display("FAIL key8_before_reset got %h want 0100", key_state_out);
    else passes++;
    for (int i = 0; i < 16 && (cyc % COL_CYCLES) != 3; i++) @(negedge clk_in);
    #2 rst_n_in = 1'b0;
    #1;
    checks++;
    if ({col_out, key_state_out, frame_out} !== {4'b1110, 16'h0000, 1'b0})
      $display("FAIL async_reset got col=%b key=%h frame=%b want col=1110 key=0000 frame=0",
               col_out, key_state_out, frame_out);
    else passes++;
    repeat (2) @(negedge clk_in);
    rst_n_in = 1'b1;
    repeat (5 * FRAME) begin
      @(negedge clk_in);
      checks++;
      if ({col_out, key_state_out, frame_out} !== {exp_col(cyc), m_key, m_frame})
        $display("FAIL key8_after_reset cyc=%0d got col=%b key=%h want col=%b key=%h",
                 cyc, col_out, key_state_out, exp_col(cyc), m_key);
      else passes++;
    end
    checks++;
    if (key_state_out !== 16'h0100) $display("FAIL key8_reasserted got %h want 0100", key_state_out);
    else passes++;
    pressed = '0;
    repeat (4 * FRAME) @(negedge clk_in);
  endtask

  task automatic test_glitch();
    for (int it = 0; it < 6; it++) begin
      int d   = $urandom_range(1, 2);
      int len = $urandom_range(1, 2);
      int row = $urandom_range(0, 3);
      for (int i = 0; i < 16 && (cyc % COL_CYCLES) != d; i++) @(negedge clk_in);
      glitch_n = ~(4'b0001 << row);
      repeat (len) @(negedge clk_in);
      glitch_n = 4'hF;
      repeat (FRAME) begin
        @(negedge clk_in);
        checks++;
        if ({col_out, key_state_out, frame_out} !== {exp_col(cyc), m_key, m_frame})
          $display("FAIL glitch cyc=%0d got key=%h want key=%h", cyc, key_state_out, m_key);
        else passes++;
      end
    end
    checks++;
    if (key_state_out !== 16'h0000) $display("FAIL glitch_ignored got %h want 0000", key_state_out);
    else passes++;
  endtask

  task automatic test_random();
    for (int it = 0; it < 16; it++) begin
      pressed = 16'($urandom) & 16'($urandom) & 16'($urandom);
      repeat ($urandom_range(20, 200)) begin
        @(negedge clk_in);
        checks++;
        if ({col_out, key_state_out, frame_out} !== {exp_col(cyc), m_key, m_frame})
          $display("FAIL random it=%0d cyc=%0d got col=%b key=%h frame=%b want col=%b key=%h frame=%b",
                   it, cyc, col_out, key_state_out, frame_out, exp_col(cyc), m_key, m_frame);
        else passes++;
      end
    end
    pressed = '0;
  endtask

  initial begin
    test_reset();
    test_idle();
    test_single_key();
    test_bounce();
    test_multi_key();
    test_reset_mid();
    test_glitch();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
